menshen_h2c_injector: RTL and testbench

- Hardware packet source that sits directly upstream of the QDMA H2C slave stream of open_nic_shell.
- Stores a sequence of 512-bit beats, each with its mty, last flag and CRC, through a simple write port.
- On a start pulse, replays the stored beats as AXI-Stream, inserting a programmable idle gap after every packet.
- Replaces file-driven stimulus so that Menshen stage configuration packets, followed by a data packet, can be injected on silicon.

---
 rtl/menshen_inj_pkg.sv | 24 ++
 rtl/menshen_inj_beat_buf.sv | 62 ++++++
 rtl/menshen_h2c_injector.sv | 171 +++++++++++++++++
 tb/tb_menshen_h2c_injector.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/menshen_inj_pkg.sv
// Shared types for the Menshen H2C packet injector.
//   AXIS_W      : stream data width
//   beat_t      : one buffered beat {data, mty, last, crc}
//   inj_state_t : replay controller states
package menshen_inj_pkg;

  localparam int unsigned AXIS_W = 512;

  typedef struct packed {
    logic [AXIS_W-1:0] data;
    logic [5:0]        mty;
    logic              last;
    logic [31:0]       crc;
  } beat_t;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    SEND,
    GAP,
    FIN
  } inj_state_t;

endpackage

// File: rtl/menshen_inj_beat_buf.sv
// Beat buffer for the H2C injector: register array with one write port and
// one combinational read port, plus write pointer and sticky overflow.
//   clk, rst_n : clock, asynchronous active-low reset
//   busy       : replay in progress; writes and clear are ignored
//   clear      : reset write pointer and overflow (while not busy)
//   wr_en      : store wr_beat at wr_ptr if not full
//   rd_addr    : read index, rd_beat is combinational
//   wr_ptr     : number of stored beats (0..DEPTH)
//   overflow   : sticky, a write was dropped because the buffer was full
module menshen_inj_beat_buf
  import menshen_inj_pkg::*;
#(
  parameter int unsigned DEPTH = 64,
  localparam int unsigned AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          busy,
  input  logic          clear,
  input  logic          wr_en,
  input  beat_t         wr_beat,
  input  logic [AW-1:0] rd_addr,
  output beat_t         rd_beat,
  output logic [AW:0]   wr_ptr,
  output logic          overflow
);

  beat_t mem [DEPTH];
  logic  full;
  logic  accept;

  assign full   = (wr_ptr == (AW+1)'(DEPTH));
  assign accept = wr_en && !busy && !clear && !full;

  // Storage carries no reset; only entries below wr_ptr are ever read.
  always_ff @(posedge clk) begin
    if (accept) begin
      mem[wr_ptr[AW-1:0]] <= wr_beat;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      overflow <= 1'b0;
    end else if (!busy) begin
      if (clear) begin
        wr_ptr   <= '0;
        overflow <= 1'b0;
      end else if (wr_en) begin
        if (full) begin
          overflow <= 1'b1;
        end else begin
          wr_ptr <= wr_ptr + (AW+1)'(1);
        end
      end
    end
  end

  assign rd_beat = mem[rd_addr];

endmodule

// File: rtl/menshen_h2c_injector.sv
// Hardware packet source for the QDMA H2C slave stream. Beats are written
// into a buffer while idle; a start pulse replays them as AXI-Stream with a
// programmable idle gap after every tlast.
//   axis_aclk, aresetn   : clock, asynchronous active-low reset
//   wr_*                 : beat write port (data, mty, last, crc)
//   clear                : empty the buffer (ignored while busy)
//   start, gap_cycles    : replay request, gap latched at start
//   m_axis_*             : AXI-Stream master (mty/crc only with tlast)
//   busy, done           : replay in progress, one-cycle completion pulse
//   overflow, wr_err     : dropped write (buffer full / replay busy)
module menshen_h2c_injector
  import menshen_inj_pkg::*;
#(
  parameter int unsigned DEPTH = 64,
  parameter int unsigned GAP_W = 8,
  parameter logic [31:0] MDATA = 32'h0000004A
) (
  input  logic              axis_aclk,
  input  logic              aresetn,
  input  logic              wr_en,
  input  logic [511:0]      wr_data,
  input  logic [5:0]        wr_mty,
  input  logic              wr_last,
  input  logic [31:0]       wr_crc,
  input  logic              clear,
  input  logic              start,
  input  logic [GAP_W-1:0]  gap_cycles,
  output logic [511:0]      m_axis_tdata,
  output logic [5:0]        m_axis_tuser_mty,
  output logic [31:0]       m_axis_tuser_mdata,
  output logic [31:0]       m_axis_tcrc,
  output logic              m_axis_tvalid,
  output logic              m_axis_tlast,
  input  logic              m_axis_tready,
  output logic              busy,
  output logic              done,
  output logic              overflow,
  output logic              wr_err
);

  localparam int unsigned AW = $clog2(DEPTH);

  inj_state_t       state;
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    rd_addr;
  logic [AW:0]      wr_ptr;
  logic [AW:0]      n_q;
  logic [GAP_W-1:0] gap_q;
  logic [GAP_W-1:0] cnt;
  beat_t            wr_beat;
  beat_t            rd_beat;
  logic             at_final;
  logic             ld_last;
  logic [5:0]       ld_mty;
  logic [31:0]      ld_crc;

  assign wr_beat = '{data: wr_data, mty: wr_mty, last: wr_last, crc: wr_crc};

  menshen_inj_beat_buf #(
    .DEPTH(DEPTH)
  ) u_buf (
    .clk      (axis_aclk),
    .rst_n    (aresetn),
    .busy     (busy),
    .clear    (clear),
    .wr_en    (wr_en),
    .wr_beat  (wr_beat),
    .rd_addr  (rd_addr),
    .rd_beat  (rd_beat),
    .wr_ptr   (wr_ptr),
    .overflow (overflow)
  );

  // In SEND the read port looks one entry ahead so a back-to-back beat can
  // be loaded in the handshake cycle; elsewhere it reads rd_ptr itself.
  assign rd_addr  = (state == SEND) ? rd_ptr + AW'(1) : rd_ptr;

  // n_q is the beat count latched at start, so a write accepted in the start
  // cycle does not extend the current replay.
  assign at_final = ({1'b0, rd_ptr} == n_q - (AW+1)'(1));
  assign ld_last  = rd_beat.last || ({1'b0, rd_addr} == n_q - (AW+1)'(1));
  assign ld_mty   = ld_last ? rd_beat.mty : '0;
  assign ld_crc   = ld_last ? rd_beat.crc : '0;

  assign m_axis_tuser_mdata = MDATA;

  always_ff @(posedge axis_aclk or negedge aresetn) begin
    if (!aresetn) begin
      state            <= IDLE;
      rd_ptr           <= '0;
      n_q              <= '0;
      gap_q            <= '0;
      cnt              <= '0;
      m_axis_tdata     <= '0;
      m_axis_tuser_mty <= '0;
      m_axis_tcrc      <= '0;
      m_axis_tvalid    <= 1'b0;
      m_axis_tlast     <= 1'b0;
      busy             <= 1'b0;
      done             <= 1'b0;
      wr_err           <= 1'b0;
    end else begin
      done   <= 1'b0;
      wr_err <= wr_en && busy;
      case (state)
        IDLE: begin
          if (start) begin
            if (wr_ptr == '0) begin
              done  <= 1'b1;
              state <= FIN;
            end else begin
              rd_ptr <= '0;
              n_q    <= wr_ptr;
              gap_q  <= gap_cycles;
              busy   <= 1'b1;
              state  <= LOAD;
            end
          end
        end
        LOAD: begin
          m_axis_tdata     <= rd_beat.data;
          m_axis_tuser_mty <= ld_mty;
          m_axis_tcrc      <= ld_crc;
          m_axis_tlast     <= ld_last;
          m_axis_tvalid    <= 1'b1;
          state            <= SEND;
        end
        SEND: begin
          if (m_axis_tready) begin
            if (at_final || (m_axis_tlast && gap_q != '0)) begin
              m_axis_tdata     <= '0;
              m_axis_tuser_mty <= '0;
              m_axis_tcrc      <= '0;
              m_axis_tlast     <= 1'b0;
              m_axis_tvalid    <= 1'b0;
              if (at_final) begin
                busy  <= 1'b0;
                done  <= 1'b1;
                state <= FIN;
              end else begin
                cnt   <= gap_q;
                state <= GAP;
              end
            end else begin
              m_axis_tdata     <= rd_beat.data;
              m_axis_tuser_mty <= ld_mty;
              m_axis_tcrc      <= ld_crc;
              m_axis_tlast     <= ld_last;
              rd_ptr           <= rd_addr;
            end
          end
        end
        GAP: begin
          // N cycles here plus the LOAD cycle give N+1 idle cycles.
          cnt <= cnt - GAP_W'(1);
          if (cnt == GAP_W'(1)) begin
            rd_ptr <= rd_ptr + AW'(1);
            state  <= LOAD;
          end
        end
        FIN: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_menshen_h2c_injector.sv
// Randomised self-checking bench for menshen_h2c_injector. A queue-based
// model of the buffer predicts the replayed beat stream and its timing.
module tb_menshen_h2c_injector;
  import menshen_inj_pkg::*;

  localparam int          DEPTH  = 64;
  localparam int          GAP_W  = 8;
  localparam logic [31:0] MDATA  = 32'h0000004A;
  localparam int          BUDGET = 4000;

  logic              axis_aclk = 1'b0;
  logic              aresetn = 1'b0;
  logic              wr_en = 1'b0;
  logic [511:0]      wr_data = '0;
  logic [5:0]        wr_mty = '0;
  logic              wr_last = 1'b0;
  logic [31:0]       wr_crc = '0;
  logic              clear = 1'b0;
  logic              start = 1'b0;
  logic [GAP_W-1:0]  gap_cycles = '0;
  logic [511:0]      m_axis_tdata;
  logic [5:0]        m_axis_tuser_mty;
  logic [31:0]       m_axis_tuser_mdata;
  logic [31:0]       m_axis_tcrc;
  logic              m_axis_tvalid;
  logic              m_axis_tlast;
  logic              m_axis_tready = 1'b0;
  logic              busy;
  logic              done;
  logic              overflow;
  logic              wr_err;

  always #5 axis_aclk = ~axis_aclk;

  menshen_h2c_injector #(
    .DEPTH(DEPTH),
    .GAP_W(GAP_W),
    .MDATA(MDATA)
  ) dut (
    .axis_aclk          (axis_aclk),
    .aresetn            (aresetn),
    .wr_en              (wr_en),
    .wr_data            (wr_data),
    .wr_mty             (wr_mty),
    .wr_last            (wr_last),
    .wr_crc             (wr_crc),
    .clear              (clear),
    .start              (start),
    .gap_cycles         (gap_cycles),
    .m_axis_tdata       (m_axis_tdata),
    .m_axis_tuser_mty   (m_axis_tuser_mty),
    .m_axis_tuser_mdata (m_axis_tuser_mdata),
    .m_axis_tcrc        (m_axis_tcrc),
    .m_axis_tvalid      (m_axis_tvalid),
    .m_axis_tlast       (m_axis_tlast),
    .m_axis_tready      (m_axis_tready),
    .busy               (busy),
    .done               (done),
    .overflow           (overflow),
    .wr_err             (wr_err)
  );

  int    errors = 0;
  int    checks = 0;
  beat_t model_q[$];
  bit    model_ovf = 1'b0;

  task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge axis_aclk);
    #1;
  endtask

  function automatic logic [511:0] rand512();
    logic [511:0] r;
    for (int i = 0; i < 16; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  function automatic beat_t rand_beat(input bit last);
    beat_t b;
    b.data = rand512();
    b.mty  = 6'($urandom_range(0, 63));
    b.last = last;
    b.crc  = $urandom;
    return b;
  endfunction

  task automatic write_beat(input beat_t b);
    wr_en   = 1'b1;
    wr_data = b.data;
    wr_mty  = b.mty;
    wr_last = b.last;
    wr_crc  = b.crc;
    tick();
    wr_en = 1'b0;
    if (model_q.size() < DEPTH) model_q.push_back(b);
    else model_ovf = 1'b1;
  endtask

  task automatic write_rand_pkt(input int n);
    for (int i = 0; i < n; i++) write_beat(rand_beat((i == n - 1) || ($urandom_range(0, 3) == 0)));
  endtask

  task automatic clear_buf();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    model_q.delete();
    model_ovf = 1'b0;
  endtask

  // Pulses start and collects the emitted stream. Cycle 0 is the start
  // cycle. inject: wr_en+start during the replay (both must be dropped).
  // also_write: a write in the start cycle (stored, but not replayed now).
  task automatic replay(input int gap, input int ready_pct, input bit inject, input bit also_write);
    beat_t exp_q[$];
    beat_t cap[$];
    int    cap_cyc[$];
    int    done_cyc;
    bit    stalled;
    beat_t held;
    beat_t cur;
    beat_t e;
    beat_t extra;
    int    n;
    int    m;

    n = model_q.size();
    for (int i = 0; i < n; i++) begin
      e = model_q[i];
      e.last = e.last || (i == n - 1);
      if (!e.last) begin
        e.mty = '0;
        e.crc = '0;
      end
      exp_q.push_back(e);
    end

    done_cyc   = -1;
    stalled    = 1'b0;
    held       = '0;
    gap_cycles = GAP_W'(gap);
    start      = 1'b1;
    extra      = rand_beat($urandom_range(0, 1) == 1);
    if (also_write) begin
      wr_en   = 1'b1;
      wr_data = extra.data;
      wr_mty  = extra.mty;
      wr_last = extra.last;
      wr_crc  = extra.crc;
    end
    tick();
    start = 1'b0;
    wr_en = 1'b0;
    if (also_write && model_q.size() < DEPTH) model_q.push_back(extra);

    for (int cyc = 1; cyc < BUDGET; cyc++) begin
      m_axis_tready = ($urandom_range(0, 99) < ready_pct);
      if (inject && cyc == 3) begin
        wr_en   = 1'b1;
        wr_data = rand512();
        start   = 1'b1;
      end else begin
        wr_en = 1'b0;
        start = 1'b0;
      end
      if (cyc == 1) check("busy_at_load", 512'(busy), 512'(n != 0));
      if (inject && cyc == 4) check("wr_err_pulse", 512'(wr_err), 512'(1));
      if (inject && cyc == 5) check("wr_err_end", 512'(wr_err), 512'(0));
      cur = '{data: m_axis_tdata, mty: m_axis_tuser_mty, last: m_axis_tlast, crc: m_axis_tcrc};
      if (stalled) begin
        check("stall_valid", 512'(m_axis_tvalid), 512'(1));
        check("stall_data", cur.data, held.data);
        check("stall_side", 512'({cur.mty, cur.last, cur.crc}), 512'({held.mty, held.last, held.crc}));
      end
      if (m_axis_tvalid && m_axis_tready) begin
        cap.push_back(cur);
        cap_cyc.push_back(cyc);
      end
      stalled = m_axis_tvalid && !m_axis_tready;
      held    = cur;
      if (done) begin
        done_cyc = cyc;
        break;
      end
      tick();
    end
    wr_en = 1'b0;
    start = 1'b0;

    if (done_cyc < 0) check("done_timeout", 512'(0), 512'(1));
    check("beat_count", 512'(cap.size()), 512'(exp_q.size()));
    m = (cap.size() < exp_q.size()) ? cap.size() : exp_q.size();
    for (int i = 0; i < m; i++) begin
      check($sformatf("b%0d.data", i), cap[i].data, exp_q[i].data);
      check($sformatf("b%0d.mty", i), 512'(cap[i].mty), 512'(exp_q[i].mty));
      check($sformatf("b%0d.last", i), 512'(cap[i].last), 512'(exp_q[i].last));
      check($sformatf("b%0d.crc", i), 512'(cap[i].crc), 512'(exp_q[i].crc));
      if (ready_pct >= 100) begin
        if (i == 0) check("first_valid_lat", 512'(cap_cyc[0]), 512'(2));
        else check($sformatf("b%0d.spacing", i), 512'(cap_cyc[i] - cap_cyc[i-1]),
                   512'((exp_q[i-1].last && gap != 0) ? gap + 2 : 1));
      end
    end
    if (done_cyc >= 0) begin
      if (exp_q.size() == 0) check("done_lat_empty", 512'(done_cyc), 512'(1));
      else if (cap.size() > 0) check("done_lat", 512'(done_cyc), 512'(cap_cyc[cap.size()-1] + 1));
    end
    tick();
    check("done_one_cycle", 512'(done), 512'(0));
    check("busy_after", 512'(busy), 512'(0));
    check("valid_after", 512'(m_axis_tvalid), 512'(0));
  endtask

  initial begin
    repeat (3) tick();
    check("rst_valid", 512'(m_axis_tvalid), 512'(0));
    check("rst_last", 512'(m_axis_tlast), 512'(0));
    check("rst_data", m_axis_tdata, 512'(0));
    check("rst_mty", 512'(m_axis_tuser_mty), 512'(0));
    check("rst_crc", 512'(m_axis_tcrc), 512'(0));
    check("rst_mdata", 512'(m_axis_tuser_mdata), 512'(32'h0000004A));
    check("rst_busy", 512'(busy), 512'(0));
    check("rst_done", 512'(done), 512'(0));
    check("rst_ovf", 512'(overflow), 512'(0));
    check("rst_wr_err", 512'(wr_err), 512'(0));
    aresetn = 1'b1;
    tick();

    // Three beats, last one carries mty 10 and a CRC.
    write_beat('{data: rand512(), mty: 6'd0, last: 1'b0, crc: 32'h0});
    write_beat('{data: rand512(), mty: 6'd0, last: 1'b0, crc: 32'h0});
    write_beat('{data: rand512(), mty: 6'd10, last: 1'b1, crc: 32'hDEADBEEF});
    replay(4, 100, 1'b0, 1'b0);
    // The buffer survives a replay.
    replay(0, 100, 1'b0, 1'b0);

    // Two one-beat packets separated by the gap.
    clear_buf();
    write_beat(rand_beat(1'b1));
    write_beat(rand_beat(1'b1));
    replay(4, 100, 1'b0, 1'b0);

    // Five-beat packet under random backpressure.
    clear_buf();
    for (int i = 0; i < 5; i++) write_beat(rand_beat(1'b0));
    replay(2, 50, 1'b0, 1'b0);

    // Overfill: 64 stored, two dropped, final beat forced last.
    clear_buf();
    for (int i = 0; i < DEPTH + 2; i++) write_beat(rand_beat($urandom_range(0, 7) == 0));
    check("overflow_set", 512'(overflow), 512'(model_ovf));
    replay(1, 100, 1'b0, 1'b0);
    check("overflow_sticky", 512'(overflow), 512'(1));
    clear_buf();
    check("overflow_cleared", 512'(overflow), 512'(0));

    // Writes and starts during a replay are dropped.
    write_rand_pkt(6);
    replay(0, 100, 1'b1, 1'b0);

    // A write in the start cycle is stored but not part of this replay.
    clear_buf();
    write_rand_pkt(2);
    replay(3, 100, 1'b0, 1'b1);
    replay(0, 100, 1'b0, 1'b0);

    // Random packets.
    for (int it = 0; it < 6; it++) begin
      clear_buf();
      write_rand_pkt($urandom_range(1, 10));
      replay($urandom_range(0, 3), ($urandom_range(0, 1) == 1) ? 100 : 60, 1'b0,
             $urandom_range(0, 1) == 1);
    end

    // Reset mid-replay drops tvalid at once and empties the buffer.
    clear_buf();
    write_rand_pkt(3);
    gap_cycles    = '0;
    m_axis_tready = 1'b1;
    start         = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    check("pre_reset_valid", 512'(m_axis_tvalid), 512'(1));
    #2;
    aresetn = 1'b0;
    #1;
    check("async_valid_drop", 512'(m_axis_tvalid), 512'(0));
    check("async_busy_drop", 512'(busy), 512'(0));
    tick();
    aresetn = 1'b1;
    model_q.delete();
    model_ovf = 1'b0;
    tick();
    replay(2, 100, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
